// File: rtl/uart_alu_sequencer.sv
// Frame controller: collects A, B and opcode bytes, drives the ALU, sends the result.
// Optional inter-byte timeout enabled with `define SEQ_TIMEOUT_EN.
module uart_alu_sequencer #(
   parameter int DBIT          = 8,
   parameter int NB_OP         = 6,
   parameter int TIMEOUT_TICKS = 640
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_tick,
   input  logic             i_rx_done,
   input  logic [DBIT-1:0]  i_rx_data,
   input  logic [DBIT-1:0]  i_alu_result,
   input  logic             i_tx_done,
   output logic [DBIT-1:0]  o_data_a,
   output logic [DBIT-1:0]  o_data_b,
   output logic [NB_OP-1:0] o_opcode,
   output logic             o_tx_start,
   output logic [DBIT-1:0]  o_tx_data,
   output logic             o_busy,
   output logic             o_overrun,
   output logic             o_frame_err
);

   typedef enum logic [2:0] {
      GET_A, GET_B, GET_OP, EXEC, SEND
   } state_t;

   state_t           state_q, state_d;
   logic [DBIT-1:0]  data_a_q, data_a_d;
   logic [DBIT-1:0]  data_b_q, data_b_d;
   logic [NB_OP-1:0] opcode_q, opcode_d;
   logic [DBIT-1:0]  tx_data_q, tx_data_d;
   logic             tx_start_q, tx_start_d;
   logic             busy_q, busy_d;
   logic             overrun_q, overrun_d;
   logic             frame_err_q, frame_err_d;
   logic             timeout;

`ifdef SEQ_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_TICKS + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign timeout = (cnt_q == CW'(TIMEOUT_TICKS));

   // Counter only runs while a frame is partially received
   always_comb begin
      cnt_d = cnt_q;
      if (i_rx_done || (state_d != state_q) ||
          !((state_q == GET_B) || (state_q == GET_OP)))
         cnt_d = '0;
      else if (i_tick && !timeout)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end
`else
   logic unused_tick;
   assign unused_tick = i_tick ^ (TIMEOUT_TICKS == 0);
   assign timeout     = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      data_a_d    = data_a_q;
      data_b_d    = data_b_q;
      opcode_d    = opcode_q;
      tx_data_d   = tx_data_q;
      tx_start_d  = 1'b0;
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
      unique case (state_q)
         GET_A: begin
            if (i_rx_done) begin
               data_a_d = i_rx_data;
               state_d  = GET_B;
            end
         end
         GET_B: begin
            if (i_rx_done) begin
               data_b_d = i_rx_data;
               state_d  = GET_OP;
            end else if (timeout) begin
               frame_err_d = 1'b1;
               state_d     = GET_A;
            end
         end
         GET_OP: begin
            if (i_rx_done) begin
               opcode_d = i_rx_data[NB_OP-1:0];
               state_d  = EXEC;
            end else if (timeout) begin
               frame_err_d = 1'b1;
               state_d     = GET_A;
            end
         end
         EXEC: begin
            tx_data_d  = i_alu_result;
            tx_start_d = 1'b1;
            overrun_d  = i_rx_done;
            state_d    = SEND;
         end
         SEND: begin
            overrun_d = i_rx_done;
            if (i_tx_done) state_d = GET_A;
         end
         default: state_d = GET_A;
      endcase
      busy_d = (state_d != GET_A);
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q     <= GET_A;
         data_a_q    <= '0;
         data_b_q    <= '0;
         opcode_q    <= '0;
         tx_data_q   <= '0;
         tx_start_q  <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_a_q    <= data_a_d;
         data_b_q    <= data_b_d;
         opcode_q    <= opcode_d;
         tx_data_q   <= tx_data_d;
         tx_start_q  <= tx_start_d;
         busy_q      <= busy_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign o_data_a    = data_a_q;
   assign o_data_b    = data_b_q;
   assign o_opcode    = opcode_q;
   assign o_tx_data   = tx_data_q;
   assign o_tx_start  = tx_start_q;
   assign o_busy      = busy_q;
   assign o_overrun   = overrun_q;
   assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Bench for uart_alu_sequencer: frame vector table, scoreboard on tx bytes,
// hand sequences for overrun, reset and inter-byte gap.
module tb_uart_alu_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tick;
   logic       rx_done;
   logic [7:0] rx_data;
   logic [7:0] alu_res;
   logic       tx_done;
   logic [7:0] data_a, data_b, tx_data;
   logic [5:0] opcode;
   logic       tx_start, busy, overrun, frame_err;

   int checks   = 0;
   int failures = 0;
   int fe_cnt   = 0;
   bit outstanding = 1'b0;
   logic [7:0] sb[$];

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] op;
      logic [5:0] opc;
      logic [7:0] res;
   } vec_t;

   vec_t vecs[7];

   always #5 clk = ~clk;

   uart_alu_sequencer dut (
      .i_clock     (clk),
      .i_reset     (rst_n),
      .i_tick      (tick),
      .i_rx_done   (rx_done),
      .i_rx_data   (rx_data),
      .i_alu_result(alu_res),
      .i_tx_done   (tx_done),
      .o_data_a    (data_a),
      .o_data_b    (data_b),
      .o_opcode    (opcode),
      .o_tx_start  (tx_start),
      .o_tx_data   (tx_data),
      .o_busy      (busy),
      .o_overrun   (overrun),
      .o_frame_err (frame_err)
   );

   // Environment ALU
   always_comb begin
      case (opcode)
         6'h20:   alu_res = data_a + data_b;
         6'h22:   alu_res = data_a - data_b;
         6'h24:   alu_res = data_a & data_b;
         6'h25:   alu_res = data_a | data_b;
         6'h26:   alu_res = data_a ^ data_b;
         default: alu_res = 8'h00;
      endcase
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (frame_err) fe_cnt++;
      if (rst_n && tx_start) begin
         checks++;
         if (outstanding) begin
            failures++;
            $display("FAIL double_start: got 2nd start expected none");
         end
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_empty: got tx %0h expected no start", tx_data);
         end else begin
            logic [7:0] e;
            e = sb.pop_front();
            if (tx_data !== e) begin
               failures++;
               $display("FAIL tx_data: got %0h expected %0h", tx_data, e);
            end
         end
         outstanding = 1'b1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_done = 1'b1;
      rx_data = b;
      step();
      rx_done = 1'b0;
   endtask

   task automatic do_tail(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] op, input logic [5:0] opc,
                          input logic [7:0] res);
      send_byte(b);
      sb.push_back(res);
      send_byte(op);
      @(negedge clk);
      chk("exec_nostart", tx_start, 0);
      chk("data_a", data_a, a);
      chk("data_b", data_b, b);
      chk("opcode", opcode, opc);
      chk("busy_exec", busy, 1);
      @(negedge clk);
      chk("start_lat", tx_start, 1);
      @(negedge clk);
      chk("start_once", tx_start, 0);
      step();
   endtask

   task automatic do_frame(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input logic [5:0] opc,
                           input logic [7:0] res);
      send_byte(a);
      do_tail(a, b, op, opc, res);
   endtask

   task automatic end_tx();
      step();
      outstanding = 1'b0;
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      @(negedge clk);
      chk("busy_idle", busy, 0);
      step();
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_a"}, data_a, 0);
      chk({nm, "_b"}, data_b, 0);
      chk({nm, "_op"}, opcode, 0);
      chk({nm, "_txd"}, tx_data, 0);
      chk({nm, "_outs"}, {tx_start, busy, overrun, frame_err}, 0);
   endtask

   initial begin
      vecs[0] = '{8'h20, 8'h07, 8'h20, 6'h20, 8'h27};
      vecs[1] = '{8'h10, 8'h05, 8'hE2, 6'h22, 8'h0B};
      vecs[2] = '{8'hF0, 8'h3C, 8'h24, 6'h24, 8'h30};
      vecs[3] = '{8'hF0, 8'h0F, 8'h25, 6'h25, 8'hFF};
      vecs[4] = '{8'hAA, 8'hFF, 8'h26, 6'h26, 8'h55};
      vecs[5] = '{8'h05, 8'h07, 8'h22, 6'h22, 8'hFE};
      vecs[6] = '{8'h01, 8'h02, 8'h60, 6'h20, 8'h03};

      rst_n = 1'b0; tick = 1'b0; rx_done = 1'b0;
      rx_data = 8'h00; tx_done = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_zero("rst");
      step();
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 7; i++) begin
         do_frame(vecs[i].a, vecs[i].b, vecs[i].op,
                  vecs[i].opc, vecs[i].res);
         end_tx();
      end

      // tx_done while idle must be ignored
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      @(negedge clk);
      chk("txdone_idle", busy, 0);
      step();

      // byte during SEND is dropped
      do_frame(8'h20, 8'h07, 8'h20, 6'h20, 8'h27);
      send_byte(8'h55);
      @(negedge clk);
      chk("ovr_pulse", overrun, 1);
      chk("ovr_keep_a", data_a, 8'h20);
      chk("ovr_busy", busy, 1);
      @(negedge clk);
      chk("ovr_once", overrun, 0);
      step();
      // rx_done together with tx_done in SEND
      outstanding = 1'b0;
      rx_done = 1'b1; rx_data = 8'h66; tx_done = 1'b1;
      step();
      rx_done = 1'b0; tx_done = 1'b0;
      @(negedge clk);
      chk("sim_ovr", overrun, 1);
      chk("sim_idle", busy, 0);
      chk("sim_keep_a", data_a, 8'h20);
      step();
      do_frame(8'h01, 8'h02, 8'h20, 6'h20, 8'h03);
      end_tx();

      // reset after operand A only
      send_byte(8'h99);
      rst_n = 1'b0;
      @(negedge clk);
      chk_zero("mid_rst");
      step();
      rst_n = 1'b1;
      step();
      do_frame(8'h10, 8'h05, 8'h22, 6'h22, 8'h0B);
      end_tx();

      // idle gap after operand A
      fe_cnt = 0;
      send_byte(8'h33);
      tick = 1'b1;
      repeat (645) step();
      tick = 1'b0;
      step();
`ifdef SEQ_TIMEOUT_EN
      chk("gap_fe", fe_cnt, 1);
      chk("gap_idle", busy, 0);
      chk("gap_keep_a", data_a, 8'h33);
      do_frame(8'h04, 8'h03, 8'h20, 6'h20, 8'h07);
      end_tx();
`else
      chk("gap_fe", fe_cnt, 0);
      chk("gap_busy", busy, 1);
      do_tail(8'h33, 8'h03, 8'h20, 6'h20, 8'h36);
      end_tx();
`endif

      chk("sb_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
